ffi_gamma: RTL

- Clocked, parametrised feed-forward inhibition stage for the spiking column.
- Spike lines are active-low; one spike step is processed per step_en.
- Counts spikes accumulated across a gamma window of GAMMA_CYCLES steps.
- Passes spikes while the running total stays within FFI_MAX; once the budget is exceeded it inhibits all lines for the rest of the window.
- Each line may fire at most once per window (refractory mask).
- Sits between the neuron-layer spike outputs and the STDP/readout logic.

---
 rtl/ffi_gamma.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ffi_gamma.sv
// ffi_gamma: feed-forward inhibition stage for the spiking column.
//
// Spikes are active-low. One spike step is processed per step_en. Effective
// spikes are those lines that are asserted and have not already fired in the
// current gamma window. They are passed while the window total stays within
// FFI_MAX. Once the total would exceed the budget, the stage inhibits every
// line for the rest of the window. A window lasts GAMMA_CYCLES steps.
//
// Optional feature macro: FFI_GAMMA_PRIORITY_EN
//   When defined, an overflowing step passes the lowest-index effective spikes
//   up to the remaining budget, and then inhibits. When undefined, an
//   overflowing step passes nothing.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   step_en      advance one spike step (inputs sampled only when high)
//   clear        synchronous window restart (wins over step_en)
//   spike_in_l   active-low input spikes           [NUM_LINES]
//   spike_out_l  active-low filtered spikes (reg)  [NUM_LINES]
//   inhibited    budget exceeded in current window
//   spike_total  spikes passed so far this window  [$clog2(FFI_MAX+1)]
//   step_idx     current step within the window    [$clog2(GAMMA_CYCLES)]
//   gamma_done   one-cycle pulse on a window's final step
module ffi_gamma #(
   parameter int NUM_LINES    = 16,
   parameter int FFI_MAX      = 4,
   parameter int GAMMA_CYCLES = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            step_en,
   input  logic                            clear,
   input  logic [NUM_LINES-1:0]            spike_in_l,
   output logic [NUM_LINES-1:0]            spike_out_l,
   output logic                            inhibited,
   output logic [$clog2(FFI_MAX+1)-1:0]    spike_total,
   output logic [$clog2(GAMMA_CYCLES)-1:0] step_idx,
   output logic                            gamma_done
);

   localparam int TW = $clog2(FFI_MAX+1);
   localparam int SW = $clog2(GAMMA_CYCLES);
   localparam int PW = $clog2(NUM_LINES+1);
   // One extra bit so that total + popcount can never wrap.
   localparam int AW = PW + 1;

   logic [NUM_LINES-1:0] spike_out_l_q, spike_out_l_d;
   logic [NUM_LINES-1:0] fired_q, fired_d;
   logic                 inhibited_q, inhibited_d;
   logic [TW-1:0]        spike_total_q, spike_total_d;
   logic [SW-1:0]        step_idx_q, step_idx_d;
   logic                 gamma_done_q, gamma_done_d;

   logic [NUM_LINES-1:0] eff;
   logic [PW-1:0]        pop;
   logic [AW-1:0]        sum;
`ifdef FFI_GAMMA_PRIORITY_EN
   logic [NUM_LINES-1:0] pass_vec;
   logic [AW-1:0]        remain;
   logic [AW-1:0]        pass_cnt;
`endif

   always_comb begin
      // Lines that already fired this window are neither passed nor counted.
      eff = ~spike_in_l & ~fired_q;
      pop = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         pop = pop + PW'(eff[i]);
      end
      sum = AW'(spike_total_q) + AW'(pop);

`ifdef FFI_GAMMA_PRIORITY_EN
      // Lowest-index effective spikes win the leftover budget.
      remain   = AW'(FFI_MAX) - AW'(spike_total_q);
      pass_vec = '0;
      pass_cnt = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (eff[i] && (pass_cnt < remain)) begin
            pass_vec[i] = 1'b1;
            pass_cnt    = pass_cnt + AW'(1);
         end
      end
`endif

      spike_out_l_d = '1;
      gamma_done_d  = 1'b0;
      fired_d       = fired_q;
      inhibited_d   = inhibited_q;
      spike_total_d = spike_total_q;
      step_idx_d    = step_idx_q;

      if (clear) begin
         fired_d       = '0;
         inhibited_d   = 1'b0;
         spike_total_d = '0;
         step_idx_d    = '0;
      end else if (step_en) begin
         if (!inhibited_q) begin
            if (sum <= AW'(FFI_MAX)) begin
               spike_out_l_d = ~eff;
               fired_d       = fired_q | eff;
               spike_total_d = TW'(sum);
            end else begin
`ifdef FFI_GAMMA_PRIORITY_EN
               spike_out_l_d = ~pass_vec;
               fired_d       = fired_q | pass_vec;
               spike_total_d = TW'(FFI_MAX);
`endif
               inhibited_d   = 1'b1;
            end
         end
         // The final step is filtered normally above; the window state is
         // then wiped so the next step starts a fresh window.
         if (step_idx_q == SW'(GAMMA_CYCLES-1)) begin
            gamma_done_d  = 1'b1;
            step_idx_d    = '0;
            spike_total_d = '0;
            inhibited_d   = 1'b0;
            fired_d       = '0;
         end else begin
            step_idx_d = step_idx_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spike_out_l_q <= '1;
         fired_q       <= '0;
         inhibited_q   <= 1'b0;
         spike_total_q <= '0;
         step_idx_q    <= '0;
         gamma_done_q  <= 1'b0;
      end else begin
         spike_out_l_q <= spike_out_l_d;
         fired_q       <= fired_d;
         inhibited_q   <= inhibited_d;
         spike_total_q <= spike_total_d;
         step_idx_q    <= step_idx_d;
         gamma_done_q  <= gamma_done_d;
      end
   end

   assign spike_out_l = spike_out_l_q;
   assign inhibited   = inhibited_q;
   assign spike_total = spike_total_q;
   assign step_idx    = step_idx_q;
   assign gamma_done  = gamma_done_q;

endmodule
